jtag_report_sched: RTL

- Owns the single debug_bridge_jtag handshake and shares it between NUM_SRC report sources (frame counter, status snapshot, audio parameter readback, etc.).
- Polls the host for command words when idle and decodes each into opcode/argument strobes for the parameter registers.
- Streams multi-word reports from the granted source, using round-robin arbitration between pending sources.

---
 rtl/jtag_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/jtag_report_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_sched_pkg.sv
// Shared types and constants for the JTAG report scheduler: FSM state encoding,
// host command opcodes and a small modulo-increment helper.
package jtag_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    GRANT,
    SEND,
    GAP
  } state_t;

  localparam logic [7:0] OP_RGB    = 8'h00;
  localparam logic [7:0] OP_FILTER = 8'h01;
  localparam logic [7:0] OP_KS     = 8'h02;
  localparam logic [7:0] OP_KSFILT = 8'h03;
  localparam logic [7:0] OP_BP     = 8'h04;
  localparam logic [7:0] OP_CHIRP  = 8'hFD;
  localparam logic [7:0] OP_REPORT = 8'hFE;
  localparam logic [7:0] OP_RESET  = 8'hFF;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N; returns one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it holding a value (which infers a latch).
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    pos   = '0;
    // Scan offsets from farthest to nearest so the nearest requester wins.
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      pos = sum[IW-1:0];
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = pos;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtag_report_sched.sv
// Shares the debug_bridge_jtag handshake between host command polling and
// round-robin multi-word report streaming. Optional macro JTAG_SCHED_TIMEOUT_EN.
module jtag_report_sched
  import jtag_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*LEN_W-1:0] src_len,
  input  logic [NUM_SRC*32-1:0]    src_d,
  output logic [NUM_SRC-1:0]       src_grant,
  output logic [LEN_W-1:0]         word_idx,
  output logic                     src_done,
  output logic                     src_abort,
  output logic                     cmd_valid,
  output logic [7:0]               cmd_op,
  output logic [23:0]              cmd_arg,
  output logic                     bridge_req,
  output logic                     bridge_wr,
  output logic [31:0]              bridge_d,
  input  logic [31:0]              bridge_q,
  input  logic                     bridge_ack
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      sel_q;
  logic [LEN_W-1:0]   len_q;
  logic               mid;

  logic [NUM_SRC-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  logic [LEN_W-1:0]   arb_len;
  logic [31:0]        sel_d;

  rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_arb (
    .req   (src_req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    arb_len = '0;
    sel_d   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (arb_idx == IW'(i)) arb_len = src_len[i*LEN_W +: LEN_W];
      if (sel_q == IW'(i))   sel_d   = src_d[i*32 +: 32];
    end
  end

`ifdef JTAG_SCHED_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt;
  logic          abort_q;
  assign src_abort = abort_q;
`else
  assign src_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      sel_q      <= '0;
      len_q      <= '0;
      mid        <= 1'b0;
      src_grant  <= '0;
      word_idx   <= '0;
      src_done   <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_op     <= '0;
      cmd_arg    <= '0;
      bridge_req <= 1'b0;
      bridge_wr  <= 1'b0;
      // NOTE: data registers are reset too because every output must read 0
      // after reset; there is no RAM here, so this costs only plain flops.
      bridge_d   <= '0;
`ifdef JTAG_SCHED_TIMEOUT_EN
      tmo_cnt    <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      src_done  <= 1'b0;
      cmd_valid <= 1'b0;
`ifdef JTAG_SCHED_TIMEOUT_EN
      abort_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|src_req) begin
            bridge_wr <= 1'b1;
            state     <= GRANT;
          end else begin
            bridge_wr  <= 1'b0;
            bridge_req <= 1'b1;
            state      <= POLL;
          end
        end

        POLL: begin
          // An ack beats a simultaneous src_req so a host command is never lost.
          if (bridge_ack) begin
            cmd_op     <= bridge_q[31:24];
            cmd_arg    <= bridge_q[23:0];
            cmd_valid  <= 1'b1;
            bridge_req <= 1'b0;
            state      <= GAP;
          end else if (|src_req) begin
            bridge_req <= 1'b0;
            state      <= GAP;
          end
        end

        GRANT: begin
          if (arb_valid) begin
            src_grant <= arb_grant;
            sel_q     <= arb_idx;
            len_q     <= arb_len;
            word_idx  <= '0;
            if (arb_len == '0) begin
              src_done <= 1'b1;
              rr_ptr   <= IW'(wrap_inc(int'(arb_idx), NUM_SRC));
              mid      <= 1'b0;
              state    <= GAP;
            end else begin
              mid   <= 1'b1;
              state <= SEND;
`ifdef JTAG_SCHED_TIMEOUT_EN
              tmo_cnt <= TMO_LOAD;
`endif
            end
          end else begin
            state <= IDLE;
          end
        end

        SEND: begin
          // First SEND cycle captures the word; req rises only once it is stable.
          if (bridge_req && bridge_ack) begin
            bridge_req <= 1'b0;
            state      <= GAP;
            if (word_idx == len_q - LEN_W'(1)) begin
              src_done <= 1'b1;
              rr_ptr   <= IW'(wrap_inc(int'(sel_q), NUM_SRC));
              mid      <= 1'b0;
            end else begin
              word_idx <= word_idx + LEN_W'(1);
            end
          end
`ifdef JTAG_SCHED_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            bridge_req <= 1'b0;
            abort_q    <= 1'b1;
            rr_ptr     <= IW'(wrap_inc(int'(sel_q), NUM_SRC));
            mid        <= 1'b0;
            state      <= GAP;
          end
`endif
          else begin
            if (!bridge_req) begin
              bridge_d   <= sel_d;
              bridge_req <= 1'b1;
            end
`ifdef JTAG_SCHED_TIMEOUT_EN
            tmo_cnt <= tmo_cnt - TW'(1);
`endif
          end
        end

        GAP: begin
          // The grant stays visible during the done/abort pulse cycle.
          if (mid) begin
            state <= SEND;
`ifdef JTAG_SCHED_TIMEOUT_EN
            tmo_cnt <= TMO_LOAD;
`endif
          end else begin
            src_grant <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
